// File: rtl/instr_encoder_if.sv
// Request/word stream between a program builder, the encoder and an instruction-memory writer.
// The encoder takes the slave modport; whatever drives requests and drains words takes master.
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_type;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport slave (
        input  in_valid, in_type, in_funct3, in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_last
    );

    modport master (
        output in_valid, in_type, in_funct3, in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_last
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs I/S/SB fields into RV32I words, buffers {instr, addr, last}; words appear 1 cycle after accept.
// in_ready drops when the buffer is full (no pass-through); out_* hold while stalled; illegal imms are dropped.
module instr_encoder #(
    parameter int                DEPTH     = 2,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_encoder_if.slave        bus,
    output logic                  err,
    output logic [7:0]            err_count,
    output logic                  done
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
    logic              last_mem_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              done_q, done_d;

    logic              accept, legal, push, pop;
    logic [6:0]        opcode;
    logic [31:0]       instr;
    logic signed [31:0] imm_s;

    assign imm_s = bus.in_imm;

    always_comb begin
        opcode = 7'b0000011;
        instr  = '0;
        legal  = 1'b0;
        unique case (bus.in_type)
            2'd0: opcode = 7'b0000011;
            2'd1: opcode = 7'b0010011;
            2'd2: opcode = 7'b0100011;
            default: opcode = 7'b1100011;
        endcase
        unique case (bus.in_type)
            2'd0, 2'd1: begin
                instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
                legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            2'd2: begin
                instr = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_imm[4:0], opcode};
                legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            default: begin
                instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_imm[4:1], bus.in_imm[11], opcode};
                legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !bus.in_imm[0];
            end
        endcase
    end

    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && legal;
    assign bus.out_valid = (count_q != '0);
    assign pop           = bus.out_valid && bus.out_ready;

    // Head is read straight from storage; gating keeps outputs at zero while empty.
    assign bus.out_instr = bus.out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign bus.out_addr  = bus.out_valid ? addr_mem_q[rd_ptr_q]  : '0;
    assign bus.out_last  = bus.out_valid ? last_mem_q[rd_ptr_q]  : 1'b0;

    assign err       = err_q;
    assign err_count = err_count_q;
    assign done      = done_q;

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        next_addr_d = next_addr_q;
        if (accept && bus.in_last) begin
            next_addr_d = BASE_ADDR;
        end else if (push) begin
            next_addr_d = next_addr_q + ADDR_W'(4);
        end
        err_d       = accept && !legal;
        err_count_d = (err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
        done_d      = pop && bus.out_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            next_addr_q <= BASE_ADDR;
            err_q       <= 1'b0;
            err_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            next_addr_q <= next_addr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= instr;
            addr_mem_q[wr_ptr_q]  <= next_addr_q;
            last_mem_q[wr_ptr_q]  <= bus.in_last;
        end
    end
endmodule
